// File: rtl/matmul_apb_regs.sv
// APB configuration/status register block for the matrix-multiplication core.
// Optional error response output PSLVERR is enabled by defining APB_PSLVERR_EN.
module matmul_apb_regs #(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 16,
    parameter int AWIDTH        = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [REG_ADDRWIDTH-1:0] PADDR,
    input  logic                     PWRITE,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic [REG_DATAWIDTH-1:0] PWDATA,
    output logic [REG_DATAWIDTH-1:0] PRDATA,
    output logic                     PREADY,
`ifdef APB_PSLVERR_EN
    output logic                     PSLVERR,
`endif
    input  logic                     done_in,
    input  logic [4:0]               flags_in,
    output logic                     start_mat_mul,
    output logic                     start_pulse,
    output logic [AWIDTH-1:0]        address_mat_a,
    output logic [AWIDTH-1:0]        address_mat_b,
    output logic [AWIDTH-1:0]        address_mat_c,
    output logic [7:0]               address_stride_a,
    output logic [7:0]               address_stride_b,
    output logic [7:0]               address_stride_c
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    apb_state_t               state;
    logic                     status_done;
    logic [4:0]               status_flags;
    logic [2:0]               reg_sel;
    logic                     upper_nz;
    logic                     commit;
    logic                     ctrl_wr;
    logic [REG_DATAWIDTH-1:0] rd_mux;
    logic                     unused_pwdata;

    assign reg_sel  = PADDR[2:0];
    assign upper_nz = (PADDR >> 3) != '0;
    assign PREADY   = PSEL & PENABLE;

    // Only the SETUP->ACCESS edge commits, so a held access phase writes once.
    assign commit  = (state == SETUP) && PSEL && PENABLE && PWRITE && !upper_nz;
    assign ctrl_wr = commit && (reg_sel == 3'd0);

    assign unused_pwdata = ^PWDATA;

`ifdef APB_PSLVERR_EN
    assign PSLVERR = PREADY & (upper_nz |
                     (PWRITE & ((reg_sel == 3'd7) | ((reg_sel != 3'd0) & start_mat_mul))));
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (PSEL && !PENABLE) state <= SETUP;
                SETUP:   if (!PSEL) state <= IDLE;
                         else if (PENABLE) state <= ACCESS;
                ACCESS:  if (!PSEL) state <= IDLE;
                         else if (!PENABLE) state <= SETUP;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_mat_mul    <= 1'b0;
            start_pulse      <= 1'b0;
            address_mat_a    <= '0;
            address_mat_b    <= '0;
            address_mat_c    <= '0;
            address_stride_a <= '0;
            address_stride_b <= '0;
            address_stride_c <= '0;
        end else begin
            start_pulse <= ctrl_wr && PWDATA[0] && !start_mat_mul;
            if (commit) begin
                case (reg_sel)
                    3'd0: start_mat_mul <= PWDATA[0];
                    3'd1: if (!start_mat_mul) address_mat_a    <= PWDATA[AWIDTH-1:0];
                    3'd2: if (!start_mat_mul) address_mat_b    <= PWDATA[AWIDTH-1:0];
                    3'd3: if (!start_mat_mul) address_mat_c    <= PWDATA[AWIDTH-1:0];
                    3'd4: if (!start_mat_mul) address_stride_a <= PWDATA[7:0];
                    3'd5: if (!start_mat_mul) address_stride_b <= PWDATA[7:0];
                    3'd6: if (!start_mat_mul) address_stride_c <= PWDATA[7:0];
                    default: ;
                endcase
            end
        end
    end

    // A CTRL write clears status and takes priority over a coincident done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_done  <= 1'b0;
            status_flags <= '0;
        end else if (ctrl_wr) begin
            status_done  <= 1'b0;
            status_flags <= '0;
        end else begin
            if (done_in) status_done <= 1'b1;
            if (start_mat_mul && !status_done) status_flags <= status_flags | flags_in;
        end
    end

    // NOTE: defaulting every always_comb output first keeps the mux free of latches.
    always_comb begin
        rd_mux = '0;
        if (!upper_nz) begin
            case (reg_sel)
                3'd0: rd_mux[0]          = start_mat_mul;
                3'd1: rd_mux[AWIDTH-1:0] = address_mat_a;
                3'd2: rd_mux[AWIDTH-1:0] = address_mat_b;
                3'd3: rd_mux[AWIDTH-1:0] = address_mat_c;
                3'd4: rd_mux[7:0]        = address_stride_a;
                3'd5: rd_mux[7:0]        = address_stride_b;
                3'd6: rd_mux[7:0]        = address_stride_c;
                3'd7: rd_mux[5:0]        = {status_flags, status_done};
            endcase
        end
    end

    // Reloading on every selected read cycle lets a held access poll STATUS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            PRDATA <= '0;
        end else if (PSEL && !PWRITE) begin
            PRDATA <= rd_mux;
        end
    end

endmodule

// File: tb/tb_matmul_apb_regs.sv
// Scoreboard bench for matmul_apb_regs: random APB traffic against a register-map model.
module tb_matmul_apb_regs;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready;
`ifdef APB_PSLVERR_EN
    logic        pslverr;
`endif
    logic        done_in = 1'b0;
    logic [4:0]  flags_in = '0;
    logic        start_mat_mul;
    logic        start_pulse;
    logic [9:0]  address_mat_a, address_mat_b, address_mat_c;
    logic [7:0]  address_stride_a, address_stride_b, address_stride_c;

    always #5 clk = ~clk;

    matmul_apb_regs #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(16), .AWIDTH(10)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .PADDR            (paddr),
        .PWRITE           (pwrite),
        .PSEL             (psel),
        .PENABLE          (penable),
        .PWDATA           (pwdata),
        .PRDATA           (prdata),
        .PREADY           (pready),
`ifdef APB_PSLVERR_EN
        .PSLVERR          (pslverr),
`endif
        .done_in          (done_in),
        .flags_in         (flags_in),
        .start_mat_mul    (start_mat_mul),
        .start_pulse      (start_pulse),
        .address_mat_a    (address_mat_a),
        .address_mat_b    (address_mat_b),
        .address_mat_c    (address_mat_c),
        .address_stride_a (address_stride_a),
        .address_stride_b (address_stride_b),
        .address_stride_c (address_stride_c)
    );

    typedef struct {
        logic        is_read;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b1;

    // Register-map model
    logic       m_start;
    logic [9:0] m_addr[3];
    logic [7:0] m_stride[3];
    logic       m_done;
    logic [4:0] m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start = 1'b0;
        m_done  = 1'b0;
        m_flags = '0;
        for (int i = 0; i < 3; i++) begin
            m_addr[i]   = '0;
            m_stride[i] = '0;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [7:0] a);
        logic [15:0] r;
        r = '0;
        if (a[7:3] == 5'd0) begin
            case (a[2:0])
                3'd0:          r = {15'd0, m_start};
                3'd1,3'd2,3'd3: r = {6'd0, m_addr[a[2:0] - 3'd1]};
                3'd4,3'd5,3'd6: r = {8'd0, m_stride[a[2:0] - 3'd4]};
                default:       r = {10'd0, m_flags, m_done};
            endcase
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_start_mat_mul"}, start_mat_mul, m_start);
        check({tag, "_addr_a"}, address_mat_a, m_addr[0]);
        check({tag, "_addr_b"}, address_mat_b, m_addr[1]);
        check({tag, "_addr_c"}, address_mat_c, m_addr[2]);
        check({tag, "_stride_a"}, address_stride_a, m_stride[0]);
        check({tag, "_stride_b"}, address_stride_b, m_stride[1]);
        check({tag, "_stride_c"}, address_stride_c, m_stride[2]);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [15:0] d, input logic with_done);
        exp_t e;
        logic upper, ctrl, exp_pulse;
        upper     = a[7:3] != 5'd0;
        ctrl      = !upper && a[2:0] == 3'd0;
        exp_pulse = 1'b0;
        e.is_read = 1'b0;
        e.data    = '0;
        e.err     = upper || a[2:0] == 3'd7 || (a[2:0] != 3'd0 && m_start);
        if (ctrl) begin
            exp_pulse = d[0] && !m_start;
            m_start   = d[0];
            m_done    = 1'b0;
            m_flags   = '0;
        end else if (!upper && !m_start) begin
            if (a[2:0] >= 3'd1 && a[2:0] <= 3'd3) m_addr[a[2:0] - 3'd1] = d[9:0];
            if (a[2:0] >= 3'd4 && a[2:0] <= 3'd6) m_stride[a[2:0] - 3'd4] = d[7:0];
        end
        if (with_done && !ctrl) m_done = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; done_in = with_done;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; done_in = 1'b0;
        check("start_pulse", start_pulse, exp_pulse);
        check_outputs("wr");
        @(posedge clk); #1;
        check("start_pulse_low", start_pulse, 1'b0);
    endtask

    task automatic apb_read(input logic [7:0] a);
        exp_t e;
        e.is_read = 1'b1;
        e.data    = model_read(a);
        e.err     = a[7:3] != 5'd0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic core_event(input logic [4:0] f, input logic d);
        if (m_start && !m_done) m_flags = m_flags | f;
        if (d) m_done = 1'b1;
        @(posedge clk); #1;
        flags_in = f;
        @(posedge clk); #1;
        flags_in = '0; done_in = d;
        @(posedge clk); #1;
        done_in = 1'b0;
    endtask

    // Monitor: pops one expectation per access phase and compares the bus response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && resetn && psel && penable) begin
                check("pready", pready, 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: access with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check("prdata", prdata, e.data);
`ifdef APB_PSLVERR_EN
                    check("pslverr", pslverr, e.err);
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        int          op;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 16'h0);
        check("rst_start_pulse", start_pulse, 1'b0);
        check_outputs("rst");
        @(negedge clk) resetn = 1'b1;

        for (int i = 0; i < 8; i++) apb_read(8'(i));

        apb_write(8'h01, 16'h0015, 1'b0);
        apb_write(8'h05, 16'h0001, 1'b0);
        apb_write(8'h00, 16'h0001, 1'b0);
        apb_read(8'h01);
        apb_read(8'h05);
        apb_write(8'h03, 16'h03FF, 1'b0);
        apb_read(8'h03);

        // Held polling read of STATUS across a flag cycle and a done pulse
        mon_en = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h07;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("poll_initial", prdata, 16'h0000);
        @(posedge clk); #1;
        flags_in = 5'b00100;
        @(posedge clk); #1;
        flags_in = '0; done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (prdata == 16'h0009) break;
        end
        check("poll_done", prdata, 16'h0009);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        m_flags = 5'b00100;
        m_done  = 1'b1;
        mon_en  = 1'b1;
        apb_read(8'h07);

        apb_write(8'h00, 16'h0000, 1'b1);
        apb_read(8'h07);

        // Reset asserted during the access phase of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 16'h0123;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 resetn = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_reset();
        check("midrst_addr_b", address_mat_b, 10'h000);
        check("midrst_prdata", prdata, 16'h0);
        @(negedge clk) resetn = 1'b1;
        apb_write(8'h02, 16'h0055, 1'b0);
        apb_read(8'h02);

        for (int n = 0; n < 120; n++) begin
            a  = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a[5] = 1'b1;
            d  = 16'($urandom);
            op = $urandom_range(0, 9);
            if (op < 4) apb_write(a, d, $urandom_range(0, 7) == 0);
            else if (op < 8) apb_read(a);
            else core_event(5'($urandom), $urandom_range(0, 1) == 1);
        end
        apb_read(8'h07);

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
